// File: rtl/udcount_pkg.sv
// Shared types for the up/down counter: counting modes and the RUN/HALT control state.
package udcount_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/udcount_prescale.sv
// Enable prescaler: strobe is high on the enabled cycle that completes each PRESCALE-cycle group.
// Only instantiated when UDCOUNT_PRESCALE_EN is defined.
module udcount_prescale
  import udcount_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic strobe
);

  // A 1-bit register is kept for PRESCALE=1; it simply stays at 0 so strobe is constant 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign strobe = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = strobe ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/udcount_mod.sv
// Up/down counter with WRAP/SAT/ONESHOT modes, clamped load, terminal-count pulse and done flag.
// Optional enable prescaler is built only when UDCOUNT_PRESCALE_EN is defined.
module udcount_mod
  import udcount_pkg::*;
#(
  parameter int     WIDTH    = 18,
  parameter longint MAX      = (longint'(1) << WIDTH) - 1,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_min,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  if (MAX < 0 || MAX > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("udcount_mod: MAX does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("udcount_mod: PRESCALE must be at least 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             strobe;
  logic             step;

`ifdef UDCOUNT_PRESCALE_EN
  udcount_prescale #(.PRESCALE(PRESCALE)) u_prescale (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr | load),
    .en     (en & (state_q == ST_RUN)),
    .strobe (strobe)
  );
`else
  assign strobe = 1'b1;
`endif

  assign at_max = (count_q == MAX_W);
  assign at_min = (count_q == '0);
  assign step   = en & strobe & (state_q == ST_RUN) & ~clr & ~load;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clr) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (load) begin
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else if (step) begin
      case (mode)
        MODE_SAT: begin
          if (up ? at_max : at_min) tc_d = 1'b1;
          else count_d = up ? count_q + ONE : count_q - ONE;
        end
        MODE_ONESHOT: begin
          // Step saturates at the bound; landing on the bound ends the run.
          if (up) count_d = at_max ? MAX_W : count_q + ONE;
          else    count_d = at_min ? '0    : count_q - ONE;
          if (up ? (count_d == MAX_W) : (count_d == '0)) begin
            tc_d    = 1'b1;
            done_d  = 1'b1;
            state_d = ST_HALT;
          end
        end
        default: begin
          if (up) begin
            count_d = at_max ? '0 : count_q + ONE;
            tc_d    = at_max;
          end else begin
            count_d = at_min ? MAX_W : count_q - ONE;
            tc_d    = at_min;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_udcount_mod.sv
// Scoreboard bench for udcount_mod (WIDTH=4, MAX=9): directed scenarios, random stimulus, prescale check.
module tb_udcount_mod;

  localparam int W  = 4;
  localparam int MX = 9;

  logic         clk = 1'b0;
  logic         rst, clr, en, up, load;
  logic [1:0]   mode;
  logic [W-1:0] load_val, count;
  logic         tc, at_max, at_min, done;

  logic         ps_clr, ps_en, ps_up, ps_load;
  logic [1:0]   ps_mode;
  logic [W-1:0] ps_load_val, ps_count;
  logic         ps_tc, ps_at_max, ps_at_min, ps_done;

  always #5 clk = ~clk;

  udcount_mod #(.WIDTH(W), .MAX(MX), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .count(count), .tc(tc),
    .at_max(at_max), .at_min(at_min), .done(done)
  );

  udcount_mod #(.WIDTH(W), .MAX(MX), .PRESCALE(3)) dut_ps (
    .clk(clk), .rst(rst), .clr(ps_clr), .en(ps_en), .up(ps_up), .mode(ps_mode),
    .load(ps_load), .load_val(ps_load_val), .count(ps_count), .tc(ps_tc),
    .at_max(ps_at_max), .at_min(ps_at_min), .done(ps_done)
  );

  typedef struct {
    int cnt;
    bit tc;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int m_count = 0;
  bit m_tc    = 0;
  bit m_done  = 0;
  bit m_halt  = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_count = 0; m_tc = 0; m_done = 0; m_halt = 0;
  endfunction

  function automatic void model_edge(bit c, bit l, int lv, bit e, bit u, int md);
    int tgt;
    int eff;
    m_tc = 0;
    if (c) begin
      m_count = 0; m_done = 0; m_halt = 0;
    end else if (l) begin
      m_count = (lv > MX) ? MX : lv; m_done = 0; m_halt = 0;
    end else if (e && !m_halt) begin
      tgt = u ? m_count + 1 : m_count - 1;
      eff = (md == 3) ? 0 : md;
      if (eff == 0) begin
        if (tgt > MX)     begin m_count = 0;  m_tc = 1; end
        else if (tgt < 0) begin m_count = MX; m_tc = 1; end
        else m_count = tgt;
      end else if (eff == 1) begin
        if (tgt > MX || tgt < 0) m_tc = 1;
        else m_count = tgt;
      end else begin
        if (tgt > MX) tgt = MX;
        if (tgt < 0)  tgt = 0;
        m_count = tgt;
        if (u ? (tgt == MX) : (tgt == 0)) begin
          m_tc = 1; m_done = 1; m_halt = 1;
        end
      end
    end
  endfunction

  // Monitor: the DUT presents a new registered result after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_count",  int'(count),  e.cnt);
        chk("sb_tc",     int'(tc),     int'(e.tc));
        chk("sb_done",   int'(done),   int'(e.done));
        chk("sb_at_max", int'(at_max), int'(e.cnt == MX));
        chk("sb_at_min", int'(at_min), int'(e.cnt == 0));
      end
    end
  end

  task automatic drive(input bit c, input bit l, input int lv, input bit e, input bit u, input int md);
    exp_t x;
    @(negedge clk);
    clr = c; load = l; load_val = W'(lv); en = e; up = u; mode = 2'(md);
    model_edge(c, l, lv, e, u, md);
    x.cnt = m_count; x.tc = m_tc; x.done = m_done;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic dchk(input string tag, input int c, input int t, input int d);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_tc"},    int'(tc),    t);
    chk({tag, "_done"},  int'(done),  d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ps_exp;
    rst = 1'b1; clr = 0; load = 0; load_val = '0; en = 0; up = 0; mode = 2'd0;
    ps_clr = 0; ps_en = 0; ps_up = 0; ps_load = 0; ps_mode = 2'd0; ps_load_val = '0;
    model_reset();
    #12;
    chk("rst_count",  int'(count),  0);
    chk("rst_tc",     int'(tc),     0);
    chk("rst_done",   int'(done),   0);
    chk("rst_at_min", int'(at_min), 1);
    chk("rst_at_max", int'(at_max), 0);
    @(negedge clk);
    rst = 1'b0;

    // WRAP: 8 -> 9, 0, 1
    drive(0, 1, 8, 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0); dchk("wrap1", 9, 0, 0);
    drive(0, 0, 0, 1, 1, 0); dchk("wrap2", 0, 1, 0);
    drive(0, 0, 0, 1, 1, 0); dchk("wrap3", 1, 0, 0);

    // SAT: 1 -> 0, 0, 0 with blocked-step pulses
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1); dchk("sat1", 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1); dchk("sat2", 0, 1, 0);
    drive(0, 0, 0, 1, 0, 1); dchk("sat3", 0, 1, 0);

    // ONESHOT: 7 -> 8, 9(done), hold in HALT even after mode change
    drive(0, 1, 7, 0, 1, 2);
    drive(0, 0, 0, 1, 1, 2); dchk("os1", 8, 0, 0);
    drive(0, 0, 0, 1, 1, 2); dchk("os2", 9, 1, 1);
    drive(0, 0, 0, 1, 1, 2); dchk("os3", 9, 0, 1);
    drive(0, 0, 0, 1, 1, 2); dchk("os4", 9, 0, 1);
    drive(0, 0, 0, 1, 0, 0); dchk("halt_hold", 9, 0, 1);
    drive(0, 1, 3, 1, 1, 2); dchk("os_reload", 3, 0, 0);

    // Load clamp and clr-over-load priority
    drive(0, 1, 14, 0, 1, 0); dchk("clamp", 9, 0, 0);
    drive(1, 1, 5, 1, 1, 0);  dchk("clr_prio", 0, 0, 0);

    // Asynchronous reset mid-cycle, then immediate resume
    drive(0, 1, 5, 0, 1, 0); dchk("pre_rst", 5, 0, 0);
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_done",  int'(done),  0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 1, 0); dchk("post_rst", 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit c, l, e, u;
      int lv, md;
      c  = ($urandom_range(0, 19) == 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = int'($urandom_range(0, 15));
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      md = int'($urandom_range(0, 3));
      drive(c, l, lv, e, u, md);
    end

    // Prescale instance: six enabled cycles from 0
    @(negedge clk);
    clr = 0; load = 0; en = 0;
    ps_clr = 1'b1;
    @(negedge clk);
    ps_clr = 1'b0; ps_en = 1'b1; ps_up = 1'b1;
    repeat (6) @(negedge clk);
    ps_en = 1'b0;
`ifdef UDCOUNT_PRESCALE_EN
    ps_exp = 2;
`else
    ps_exp = 6;
`endif
    chk("prescale_count", int'(ps_count), ps_exp);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udcount_mod.md
UDCOUNT_MOD -- requirements
Module: udcount_mod

Interface
REQ-001 Parameters SHALL be:
  - WIDTH, default 18, counter width in bits.
  - MAX, default 2**WIDTH-1, terminal value; count range is 0..MAX.
  - PRESCALE, default 1, enabled cycles per count step.
REQ-002 Ports SHALL be:
  - clk  in  1  clock; all state on rising edge.
  - rst  in  1  reset, asynchronous, active-high.
  - clr  in  1  synchronous clear.
  - en  in  1  count enable.
  - up  in  1  direction; 1 = increment, 0 = decrement.
  - mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = treated as WRAP.
  - load  in  1  synchronous load strobe.
  - load_val  in  WIDTH  value to load.
  - count  out  WIDTH  current count, registered.
  - tc  out  1  terminal-count pulse, registered.
  - at_max  out  1  count == MAX, combinational from count.
  - at_min  out  1  count == 0, combinational from count.
  - done  out  1  one-shot complete, registered.

Function
REQ-003 Per-edge priority SHALL be rst > clr > load > step.
REQ-004 clr SHALL set count=0, done=0, FSM=RUN and prescaler=0; tc=0 that cycle.
REQ-005 load SHALL set count=min(load_val, MAX), done=0, FSM=RUN and prescaler=0; tc=0 that cycle.
REQ-006 A step SHALL occur only when en=1, the prescale strobe is true, FSM=RUN, and neither clr nor load is asserted.
REQ-007 The step target SHALL be count+1 when up=1 and count-1 when up=0, computed without leaving 0..MAX.
REQ-008 WRAP: an up step at MAX SHALL give 0 and a down step at 0 SHALL give MAX; tc=1 in the cycle the wrapped value appears.
REQ-009 SAT: a step attempted at the bound (up at MAX, down at 0) SHALL hold count and pulse tc for one cycle per blocked step.
REQ-010 ONESHOT: a step whose result equals the bound in the counting direction SHALL load that value, pulse tc once, set done=1 and move FSM RUN->HALT.
REQ-011 In HALT, count and tc=0 SHALL hold regardless of en, up or mode until clr, load or rst; each returns FSM to RUN.
REQ-012 The FSM SHALL have exactly two states, RUN and HALT; HALT is reachable only through REQ-010.
REQ-013 tc SHALL be 0 in every cycle not named in REQ-008..010; tc is never high for two cycles from a single step.
REQ-014 Changing mode or up mid-count SHALL take effect on the next step, with no loss of count.
REQ-015 at_max and at_min SHALL both be 1 only when MAX=0.

Reset
REQ-016 rst SHALL immediately force count=0, tc=0, done=0, FSM=RUN and prescaler=0, independent of clk.
REQ-017 Counting SHALL resume on the first rising clk edge after rst deasserts, with no extra idle cycle.

Configuration
REQ-018 Macro UDCOUNT_PRESCALE_EN defined:
  - an internal counter of width clog2(PRESCALE) SHALL advance on each cycle with en=1 and FSM=RUN;
  - it SHALL assert the strobe when it reaches PRESCALE-1, then return to 0.
REQ-019 Macro UDCOUNT_PRESCALE_EN undefined: strobe SHALL equal 1, PRESCALE SHALL be ignored, and no prescale register is generated.
REQ-020 PRESCALE=1 with the macro defined SHALL behave cycle-identically to the macro undefined.

Structure
REQ-021 Package udcount_pkg SHALL hold the mode_t enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the state_t enum (ST_RUN, ST_HALT).
REQ-022 The prescaler SHALL be sub-module udcount_prescale, with ports clk, rst, clr, en and strobe; it is instantiated only under UDCOUNT_PRESCALE_EN.
REQ-023 An elaboration check SHALL reject MAX > 2**WIDTH-1 and PRESCALE < 1.

Verification (WIDTH=4, MAX=9, PRESCALE=1 unless stated)
REQ-024 WRAP: load 8, then en=1, up=1 for 3 cycles -> count 9, 0, 1; tc=1 only with count=0.
REQ-025 SAT: load 1, then en=1, up=0 for 3 cycles -> count 0, 0, 0; tc=0, 1, 1.
REQ-026 ONESHOT: load 7, then en=1, up=1 for 4 cycles -> count 8, 9, 9, 9; tc=1 and done=1 with the first 9; then load 3 -> count 3, done=0.
REQ-027 Priority and clamp:
  - load_val=14 -> count 9;
  - load=1, clr=1 in the same cycle -> count 0;
  - load=1 with en=1 -> loaded value, no step.
REQ-028 Reset: rst pulse mid-cycle while count=5 -> count 0 before the next edge; the first edge after release steps to 1 (en=1, up=1).
REQ-029 Prescale: PRESCALE=3, 6 cycles of en=1, up=1 from 0 -> count 2 with the macro defined, count 6 with it undefined.
